// File: rtl/lut_sweeper_pkg.sv
// Shared types and constants for the LUT sweeper family.
// No logic; pure declarations.
// No backpressure.
package lut_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_INIT = 8'h70;

    function automatic int table_w(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/lut_sweeper_if.sv
// Bundle between the input register file and the LUT sweeper; ones_cnt exists only with LUT_SWEEP_COUNT_EN.
// No latency (wires only).
// No backpressure; sweep results stream unconditionally.
interface lut_sweeper_if #(
    parameter int N_IN = 3
);
    import lut_sweeper_pkg::*;

    localparam int TW = table_w(N_IN);

    logic            load;
    logic [TW-1:0]   load_data;
    logic [N_IN-1:0] in_vec;
    logic            s;
    logic            start;
    logic            busy;
    logic            done;
    logic            sweep_valid;
    logic [N_IN-1:0] sweep_idx;
    logic            sweep_out;
`ifdef LUT_SWEEP_COUNT_EN
    logic [N_IN:0]   ones_cnt;

    modport master (
        output load, load_data, in_vec, start,
        input  s, busy, done, sweep_valid, sweep_idx, sweep_out, ones_cnt
    );
    modport slave (
        input  load, load_data, in_vec, start,
        output s, busy, done, sweep_valid, sweep_idx, sweep_out, ones_cnt
    );
`else
    modport master (
        output load, load_data, in_vec, start,
        input  s, busy, done, sweep_valid, sweep_idx, sweep_out
    );
    modport slave (
        input  load, load_data, in_vec, start,
        output s, busy, done, sweep_valid, sweep_idx, sweep_out
    );
`endif

endinterface

// File: rtl/lut_sweeper_counter.sv
// N+1 bit sweep index counter with clear, enable and a last-entry flag.
// Latency: count updates one edge after clr/en.
// No backpressure.
module sweep_counter #(
    parameter int N = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [N:0] cnt,
    output logic       last
);

    localparam logic [N:0] LAST_IDX = {1'b0, {N{1'b1}}};
    localparam logic [N:0] ONE      = (N+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + ONE;
        end
    end

    assign last = (cnt == LAST_IDX);

endmodule

// File: rtl/lut_sweeper.sv
// Programmable N-input truth table with exhaustive sweep; LUT_SWEEP_COUNT_EN adds a ones counter.
// Latency: s one cycle after in_vec; sweep entries start one cycle after start.
// No backpressure: load/start are dropped outside IDLE, sweep output streams every cycle.
module lut_sweeper
    import lut_sweeper_pkg::*;
#(
    parameter int                        N_IN = 3,
    parameter logic [table_w(N_IN)-1:0]  INIT = (table_w(N_IN))'(DEFAULT_INIT)
) (
    input  logic         clk,
    input  logic         rst,
    lut_sweeper_if.slave bus
);

    localparam int              TW  = table_w(N_IN);
    localparam logic [N_IN-1:0] ONE = N_IN'(1);

    state_t          state;
    logic [TW-1:0]   tbl;
    logic [TW-1:0]   sweep_tbl;
    logic [N_IN:0]   cnt;
    logic            cnt_last;
    logic            cnt_en;
    logic            load_ok;
    logic            start_ok;
    logic [N_IN-1:0] nxt_idx;

    assign load_ok   = bus.load  && (state == IDLE);
    assign start_ok  = bus.start && (state == IDLE);
    // Top bit stops the counter from running past the final entry.
    assign cnt_en    = (state == SWEEP) && !cnt[N_IN];
    assign nxt_idx   = cnt[N_IN-1:0] + ONE;
    // A load accepted together with start must be visible to the first entry.
    assign sweep_tbl = load_ok ? bus.load_data : tbl;

    assign bus.sweep_idx = cnt[N_IN-1:0];

    sweep_counter #(.N(N_IN)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok),
        .en   (cnt_en),
        .cnt  (cnt),
        .last (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl   <= INIT;
            bus.s <= 1'b0;
        end else begin
            bus.s <= tbl[bus.in_vec];
            if (load_ok) begin
                tbl <= bus.load_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.sweep_valid <= 1'b0;
            bus.sweep_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state           <= SWEEP;
                        bus.busy        <= 1'b1;
                        bus.sweep_valid <= 1'b1;
                        bus.sweep_out   <= sweep_tbl[0];
                    end
                end
                SWEEP: begin
                    if (cnt_last) begin
                        state           <= DONE;
                        bus.done        <= 1'b1;
                        bus.sweep_valid <= 1'b0;
                        bus.sweep_out   <= 1'b0;
                    end else begin
                        bus.sweep_out   <= tbl[nxt_idx];
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LUT_SWEEP_COUNT_EN
    localparam logic [N_IN:0] CNT_ONE  = (N_IN+1)'(1);
    localparam logic [N_IN:0] CNT_FULL = (N_IN+1)'(TW);

    logic [N_IN:0] ones;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones <= '0;
        end else if (start_ok) begin
            ones <= '0;
        end else if ((state == SWEEP) && bus.sweep_out && (ones != CNT_FULL)) begin
            ones <= ones + CNT_ONE;
        end
    end

    assign bus.ones_cnt = ones;
`endif

endmodule

// File: tb/tb_lut_sweeper.sv
// Scoreboard bench for lut_sweeper: N_IN=3 default table and N_IN=2 custom table.
module tb_lut_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lut_sweeper_if #(.N_IN(3)) if3();
    lut_sweeper_if #(.N_IN(2)) if2();

    lut_sweeper #(.N_IN(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    lut_sweeper #(.N_IN(2), .INIT(4'b0110)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    int total = 0;
    int bad   = 0;
    int q3[$];
    int q2[$];
    int vld3  = 0;
    int vld2  = 0;
    int done3 = 0;
    int done2 = 0;
    int d0;
    logic [7:0] mtbl3;
    logic [7:0] exp_s  = 8'b0111_0000;
    logic [3:0] mtbl2  = 4'b0110;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every reported sweep entry must match the next queued expectation.
    always @(negedge clk) begin
        if (if3.sweep_valid) begin
            vld3++;
            if (q3.size() == 0) begin
                check("sw3_extra", 1, 0);
            end else begin
                int e;
                e = q3.pop_front();
                check("sw3_idx", int'(if3.sweep_idx), e >> 1);
                check("sw3_out", int'(if3.sweep_out), e & 1);
            end
        end
        if (if2.sweep_valid) begin
            vld2++;
            if (q2.size() == 0) begin
                check("sw2_extra", 1, 0);
            end else begin
                int e;
                e = q2.pop_front();
                check("sw2_idx", int'(if2.sweep_idx), e >> 1);
                check("sw2_out", int'(if2.sweep_out), e & 1);
            end
        end
        if (if3.done) done3++;
        if (if2.done) done2++;
    end

    task automatic start_sweep3();
        for (int i = 0; i < 8; i++) q3.push_back(i * 2 + int'(mtbl3[i]));
        if3.start = 1'b1;
        @(negedge clk);
        if3.start = 1'b0;
    endtask

    task automatic wait_done3(input int lim);
        int seen = 0;
        for (int i = 0; i < lim && seen == 0; i++) begin
            @(negedge clk);
            if (if3.done) seen = 1;
        end
        check("done3_seen", seen, 1);
    endtask

    task automatic wait_done2(input int lim);
        int seen = 0;
        for (int i = 0; i < lim && seen == 0; i++) begin
            @(negedge clk);
            if (if2.done) seen = 1;
        end
        check("done2_seen", seen, 1);
    endtask

    initial begin
        if3.load = 1'b0; if3.load_data = '0; if3.in_vec = '0; if3.start = 1'b0;
        if2.load = 1'b0; if2.load_data = '0; if2.in_vec = '0; if2.start = 1'b0;
        mtbl3 = 8'h70;

        @(negedge clk);
        check("rst_s",     int'(if3.s), 0);
        check("rst_busy",  int'(if3.busy), 0);
        check("rst_done",  int'(if3.done), 0);
        check("rst_vld",   int'(if3.sweep_valid), 0);
        check("rst_out",   int'(if3.sweep_out), 0);
        check("rst_idx",   int'(if3.sweep_idx), 0);
`ifdef LUT_SWEEP_COUNT_EN
        check("rst_ones",  int'(if3.ones_cnt), 0);
`endif
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            if3.in_vec = 3'(v);
            @(negedge clk);
            check("s_eval", int'(if3.s), int'(exp_s[v]));
        end

        // Default-table sweep.
        vld3 = 0;
        start_sweep3();
        wait_done3(20);
        check("sw1_cnt",   vld3, 8);
        check("sw1_busy",  int'(if3.busy), 1);
        check("sw1_qleft", q3.size(), 0);
`ifdef LUT_SWEEP_COUNT_EN
        check("sw1_ones",  int'(if3.ones_cnt), 3);
`endif
        // start during the done cycle must be dropped.
        if3.start = 1'b1;
        @(negedge clk);
        if3.start = 1'b0;
        check("idle_busy", int'(if3.busy), 0);
        check("idle_done", int'(if3.done), 0);

        // First IDLE cycle: load + start together, sweep uses the new table.
        vld3 = 0;
        d0 = done3;
        if3.in_vec = 3'b100;
        if3.load = 1'b1;
        if3.load_data = 8'hA5;
        mtbl3 = 8'hA5;
        start_sweep3();
        if3.load = 1'b0;
        check("ld_s_old", int'(if3.s), 1);
        check("ld_busy",  int'(if3.busy), 1);
        @(negedge clk);
        check("ld_s_new", int'(if3.s), 0);
        // load and start mid-sweep are both ignored.
        if3.load = 1'b1;
        if3.load_data = 8'hFF;
        if3.start = 1'b1;
        @(negedge clk);
        if3.load = 1'b0;
        if3.start = 1'b0;
        wait_done3(20);
        check("sw2_cnt",   vld3, 8);
`ifdef LUT_SWEEP_COUNT_EN
        check("sw2_ones",  int'(if3.ones_cnt), 4);
`endif
        for (int i = 0; i < 6; i++) @(negedge clk);
        check("sw2_dones", done3 - d0, 1);
        check("sw2_qleft", q3.size(), 0);
        check("frozen_s",  int'(if3.s), 0);

        // Reset during the third sweep entry.
        d0 = done3;
        start_sweep3();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("ab_vld",  int'(if3.sweep_valid), 0);
        check("ab_busy", int'(if3.busy), 0);
        check("ab_done", int'(if3.done), 0);
        check("ab_out",  int'(if3.sweep_out), 0);
        check("ab_idx",  int'(if3.sweep_idx), 0);
        check("ab_s",    int'(if3.s), 0);
`ifdef LUT_SWEEP_COUNT_EN
        check("ab_ones", int'(if3.ones_cnt), 0);
`endif
        check("ab_qleft", q3.size(), 5);
        q3.delete();
        mtbl3 = 8'h70;
        @(negedge clk);
        rst = 1'b0;
        if3.in_vec = 3'b100;
        @(negedge clk);
        check("ab_s_init", int'(if3.s), int'(mtbl3[4]));
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("ab_nodone", done3 - d0, 0);

        // Two-input instance with its own reset table.
        vld2 = 0;
        for (int i = 0; i < 4; i++) q2.push_back(i * 2 + int'(mtbl2[i]));
        if2.start = 1'b1;
        @(negedge clk);
        if2.start = 1'b0;
        wait_done2(12);
        check("n2_cnt",   vld2, 4);
        check("n2_qleft", q2.size(), 0);
`ifdef LUT_SWEEP_COUNT_EN
        check("n2_ones",  int'(if2.ones_cnt), 2);
`endif
        @(negedge clk);
        check("n2_busy", int'(if2.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
